// File: rtl/ddr3_arb_pkg.sv
// Purpose: shared constants and types for the two-client DDR3 port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: IP command codes, arbiter state encoding, client-id width, one-hot helper.
package ddr3_arb_pkg;

    // DDR3 IP native command codes
    localparam logic [2:0] WR_CMD = 3'h0;
    localparam logic [2:0] RD_CMD = 3'h1;

    // One-hot arbiter states
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ARB   = 3'b010,
        WDATA = 3'b100
    } arb_state_e;

    // Two clients -> one bit of client id
    localparam int CID_W = 1;

    function automatic logic [1:0] cid_onehot(input logic [CID_W-1:0] id);
        cid_onehot = 2'b01 << id;
    endfunction

endpackage

// File: rtl/ddr3_rd_tag_fifo.sv
// Purpose: outstanding-read tag queue, remembers which client issued each read burst.
// Latency: push visible at head one cycle later; head is show-ahead (combinational read).
// Backpressure: push ignored when full, pop ignored when empty; caller gates via count_o.
// Ports: clk_ref/rst_n clock and async active-low reset; push_i/push_dat_i enqueue;
//        pop_i dequeue; head_dat_o oldest tag; count_o occupancy; empty_o queue empty.
module ddr3_rd_tag_fifo #(
    parameter int  DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_ref,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          push_dat_i,
    input  logic          pop_i,
    output logic          head_dat_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    logic          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = cnt_q;

    // Storage needs no reset: occupancy gates every read of it
    always_ff @(posedge clk_ref) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Purpose: shares one DDR3 IP command/data port between two burst clients, whole-burst grants.
// Latency: command/grant registered one cycle after decision; write data and read return combinational.
// Backpressure: ddr3_wr_rdy stalls write beats; cmd_rdy/full tag queue hold requests (client keeps cli_req).
// Ports: clk_ref/rst_n clock, async active-low reset; init_done calibration done;
//        cmd/cmd_en/addr + cmd_rdy IP command; ddr3_wren/ddr3_wr_end/ddr3_wr_data + ddr3_wr_rdy IP write;
//        ddr3_rd_valid/ddr3_rd_data IP read; cli_* per-client request, grant, write ack, read return;
//        rd_orphan sticky flag for read beats with no outstanding read.
// Build option: define DDR3_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties), else round-robin.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int DQ_WIDTH       = 16,
    parameter int ADDR_WIDTH     = 27,
    parameter int BURST_LEN      = 64,
    parameter int RD_OUTSTANDING = 4
) (
    input  logic                      clk_ref,
    input  logic                      rst_n,
    input  logic                      init_done,
    input  logic                      cmd_rdy,
    input  logic                      ddr3_wr_rdy,
    input  logic                      ddr3_rd_valid,
    input  logic [8*DQ_WIDTH-1:0]     ddr3_rd_data,
    output logic [2:0]                cmd,
    output logic                      cmd_en,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic                      ddr3_wren,
    output logic                      ddr3_wr_end,
    output logic [8*DQ_WIDTH-1:0]     ddr3_wr_data,
    input  logic [1:0]                cli_req,
    input  logic [1:0]                cli_we,
    input  logic [2*ADDR_WIDTH-1:0]   cli_addr,
    input  logic [2*8*DQ_WIDTH-1:0]   cli_wdata,
    output logic [1:0]                cli_grant,
    output logic [1:0]                cli_wack,
    output logic [1:0]                cli_rvalid,
    output logic [8*DQ_WIDTH-1:0]     cli_rdata,
    output logic                      rd_orphan
);

    localparam int DW     = 8 * DQ_WIDTH;
    localparam int BN     = BURST_LEN / 8;
    localparam int BCW    = (BN > 1) ? $clog2(BN) : 1;
    localparam int TAG_CW = $clog2(RD_OUTSTANDING) + 1;
    localparam logic [BCW-1:0]    LAST_BEAT = BCW'(BN - 1);
    localparam logic [TAG_CW-1:0] TAG_MAX   = TAG_CW'(RD_OUTSTANDING);

    arb_state_e             state_q;
    logic [2:0]             cmd_q;
    logic                   cmd_en_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [1:0]             grant_q;
    logic [CID_W-1:0]       owner_q;
    logic [BCW-1:0]         wbeat_q;
    logic [BCW-1:0]         rbeat_q;
    logic                   orphan_q;

    logic [1:0]             elig;
    logic                   any_elig;
    logic [CID_W-1:0]       win;
    logic                   win_we;
    logic [ADDR_WIDTH-1:0]  addr_sel;
    logic                   wr_go;
    logic                   rd_hit;
    logic                   tag_push;
    logic                   tag_pop;
    logic                   tag_head;
    logic [TAG_CW-1:0]      tag_cnt;
    logic                   tag_empty;
    logic                   tag_full;

    assign tag_full = (tag_cnt == TAG_MAX);

    // cmd_en_q blanks eligibility so commands are always at least two cycles apart.
    // Full uses the registered count only: a same-cycle pop does not free a slot.
    assign elig[0] = (state_q == ARB) && cli_req[0] && cmd_rdy && !cmd_en_q &&
                     (cli_we[0] ? ddr3_wr_rdy : !tag_full);
    assign elig[1] = (state_q == ARB) && cli_req[1] && cmd_rdy && !cmd_en_q &&
                     (cli_we[1] ? ddr3_wr_rdy : !tag_full);
    assign any_elig = |elig;

`ifdef DDR3_ARB_FIXED_PRIO_EN
    assign win = elig[0] ? 1'b0 : 1'b1;
`else
    // prio_q names the client that wins a tie; it flips away from each winner
    logic prio_q;

    assign win = (&elig) ? prio_q : elig[1];

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (any_elig) begin
            prio_q <= ~win;
        end
    end
`endif

    assign win_we   = cli_we[win];
    assign addr_sel = win ? cli_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : cli_addr[ADDR_WIDTH-1:0];
    assign tag_push = any_elig && !win_we;

    // Command FSM with registered command outputs
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= WR_CMD;
            cmd_en_q <= 1'b0;
            addr_q   <= '0;
            grant_q  <= 2'b00;
            owner_q  <= '0;
            wbeat_q  <= '0;
        end else begin
            cmd_en_q <= 1'b0;
            grant_q  <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (init_done) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    if (any_elig) begin
                        cmd_q    <= win_we ? WR_CMD : RD_CMD;
                        cmd_en_q <= 1'b1;
                        addr_q   <= addr_sel;
                        grant_q  <= cid_onehot(win);
                        if (win_we) begin
                            owner_q <= win;
                            wbeat_q <= '0;
                            state_q <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (wr_go) begin
                        wbeat_q <= wbeat_q + BCW'(1);
                        if (wbeat_q == LAST_BEAT) begin
                            state_q <= ARB;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd       = cmd_q;
    assign cmd_en    = cmd_en_q;
    assign addr      = addr_q;
    assign cli_grant = grant_q;

    // Write data: one beat per ddr3_wr_rdy cycle, straight from the owner's show-ahead word
    assign wr_go        = (state_q == WDATA) && ddr3_wr_rdy;
    assign ddr3_wren    = wr_go;
    assign ddr3_wr_end  = wr_go;
    assign ddr3_wr_data = owner_q ? cli_wdata[2*DW-1:DW] : cli_wdata[DW-1:0];
    assign cli_wack     = wr_go ? cid_onehot(owner_q) : 2'b00;

    // Read return: beats go to the client at the head of the tag queue
    assign rd_hit     = ddr3_rd_valid && !tag_empty;
    assign cli_rvalid = rd_hit ? cid_onehot(tag_head) : 2'b00;
    assign cli_rdata  = ddr3_rd_data;
    assign tag_pop    = rd_hit && (rbeat_q == LAST_BEAT);
    assign rd_orphan  = orphan_q;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            rbeat_q  <= '0;
            orphan_q <= 1'b0;
        end else if (ddr3_rd_valid) begin
            if (tag_empty) begin
                orphan_q <= 1'b1;
            end else if (rbeat_q == LAST_BEAT) begin
                rbeat_q <= '0;
            end else begin
                rbeat_q <= rbeat_q + BCW'(1);
            end
        end
    end

    ddr3_rd_tag_fifo #(
        .DEPTH (RD_OUTSTANDING)
    ) u_tag_fifo (
        .clk_ref    (clk_ref),
        .rst_n      (rst_n),
        .push_i     (tag_push),
        .push_dat_i (win),
        .pop_i      (tag_pop),
        .head_dat_o (tag_head),
        .count_o    (tag_cnt),
        .empty_o    (tag_empty)
    );

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Purpose: self-checking bench for ddr3_port_arbiter (default parameters, BN = 8, 4 tags).
// Latency: inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: bench plays both clients and the DDR3 IP, including ddr3_wr_rdy stalls.
module tb_ddr3_port_arbiter;

    localparam int AW = 27;
    localparam int DW = 128;

    logic            clk_ref;
    logic            rst_n;
    logic            init_done;
    logic            cmd_rdy;
    logic            ddr3_wr_rdy;
    logic            ddr3_rd_valid;
    logic [DW-1:0]   ddr3_rd_data;
    logic [2:0]      cmd;
    logic            cmd_en;
    logic [AW-1:0]   addr;
    logic            ddr3_wren;
    logic            ddr3_wr_end;
    logic [DW-1:0]   ddr3_wr_data;
    logic [1:0]      cli_req;
    logic [1:0]      cli_we;
    logic [2*AW-1:0] cli_addr;
    logic [2*DW-1:0] cli_wdata;
    logic [1:0]      cli_grant;
    logic [1:0]      cli_wack;
    logic [1:0]      cli_rvalid;
    logic [DW-1:0]   cli_rdata;
    logic            rd_orphan;

    ddr3_port_arbiter dut (
        .clk_ref       (clk_ref),
        .rst_n         (rst_n),
        .init_done     (init_done),
        .cmd_rdy       (cmd_rdy),
        .ddr3_wr_rdy   (ddr3_wr_rdy),
        .ddr3_rd_valid (ddr3_rd_valid),
        .ddr3_rd_data  (ddr3_rd_data),
        .cmd           (cmd),
        .cmd_en        (cmd_en),
        .addr          (addr),
        .ddr3_wren     (ddr3_wren),
        .ddr3_wr_end   (ddr3_wr_end),
        .ddr3_wr_data  (ddr3_wr_data),
        .cli_req       (cli_req),
        .cli_we        (cli_we),
        .cli_addr      (cli_addr),
        .cli_wdata     (cli_wdata),
        .cli_grant     (cli_grant),
        .cli_wack      (cli_wack),
        .cli_rvalid    (cli_rvalid),
        .cli_rdata     (cli_rdata),
        .rd_orphan     (rd_orphan)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    we;
        logic          wr_rdy;
        logic          rd_v;
        logic          en;
        logic [1:0]    gnt;
        logic [1:0]    wack;
        logic [1:0]    rv;
        logic [2:0]    ecmd;
        logic [AW-1:0] eaddr;
    } vec_t;

    localparam int NVEC = 33;
    vec_t tbl [NVEC];

    int         n_chk;
    int         n_err;
    int         widx [2];
    logic [1:0] wack_seen;
    int         model_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] wpat(input int c, input int k);
        return {8'(160 + c), 88'h0, 32'(k)};
    endfunction

    // Advance to the next cycle; a client moves to its next word after a consumed one
    task automatic next_cycle();
        @(posedge clk_ref);
        #1;
        for (int c = 0; c < 2; c++) begin
            if (wack_seen[c]) widx[c]++;
        end
        cli_wdata = {wpat(1, widx[1]), wpat(0, widx[0])};
    endtask

    task automatic settle();
        @(negedge clk_ref);
        wack_seen = cli_wack;
    endtask

    task automatic row(input int i, input logic [1:0] rq, input logic [1:0] w, input logic wr,
                       input logic rvin, input logic en, input logic [1:0] g, input logic [1:0] wk,
                       input logic [1:0] rvo, input logic [2:0] ec, input logic [AW-1:0] ea);
        tbl[i].req = rq;  tbl[i].we = w;    tbl[i].wr_rdy = wr; tbl[i].rd_v = rvin;
        tbl[i].en  = en;  tbl[i].gnt = g;   tbl[i].wack = wk;   tbl[i].rv = rvo;
        tbl[i].ecmd = ec; tbl[i].eaddr = ea;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] eg;
        logic [1:0] ev;
        n_chk = 0;
        n_err = 0;
        widx[0] = 0;
        widx[1] = 0;
        wack_seen = 2'b00;
        rst_n = 1'b0;
        init_done = 1'b0;
        cmd_rdy = 1'b1;
        ddr3_wr_rdy = 1'b0;
        ddr3_rd_valid = 1'b0;
        ddr3_rd_data = '0;
        cli_req = 2'b00;
        cli_we = 2'b00;
        cli_addr = {27'h80, 27'h40};
        cli_wdata = {wpat(1, 0), wpat(0, 0)};

        // Write by client 0 (no stalls), read by client 1, write by client 0 with
        // ddr3_wr_rdy stalls while client 1's read returns, then client 1's held write.
        row(0,  2'b01, 2'b01, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'h0, 27'h0);
        row(1,  2'b00, 2'b00, 1, 0, 1, 2'b01, 2'b01, 2'b00, 3'h0, 27'h40);
        for (int i = 2; i <= 8; i++) row(i, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b01, 2'b00, 3'h0, 27'h0);
        row(9,  2'b10, 2'b00, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'h0, 27'h0);
        row(10, 2'b00, 2'b00, 1, 0, 1, 2'b10, 2'b00, 2'b00, 3'h1, 27'h80);
        row(11, 2'b01, 2'b01, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'h0, 27'h0);
        row(12, 2'b00, 2'b00, 1, 0, 1, 2'b01, 2'b01, 2'b00, 3'h0, 27'h40);
        row(13, 2'b10, 2'b10, 0, 1, 0, 2'b00, 2'b00, 2'b10, 3'h0, 27'h0);
        row(14, 2'b10, 2'b10, 1, 1, 0, 2'b00, 2'b01, 2'b10, 3'h0, 27'h0);
        row(15, 2'b10, 2'b10, 0, 1, 0, 2'b00, 2'b00, 2'b10, 3'h0, 27'h0);
        row(16, 2'b10, 2'b10, 1, 1, 0, 2'b00, 2'b01, 2'b10, 3'h0, 27'h0);
        row(17, 2'b10, 2'b10, 1, 1, 0, 2'b00, 2'b01, 2'b10, 3'h0, 27'h0);
        row(18, 2'b10, 2'b10, 0, 1, 0, 2'b00, 2'b00, 2'b10, 3'h0, 27'h0);
        row(19, 2'b10, 2'b10, 1, 1, 0, 2'b00, 2'b01, 2'b10, 3'h0, 27'h0);
        row(20, 2'b10, 2'b10, 1, 1, 0, 2'b00, 2'b01, 2'b10, 3'h0, 27'h0);
        row(21, 2'b10, 2'b10, 1, 0, 0, 2'b00, 2'b01, 2'b00, 3'h0, 27'h0);
        row(22, 2'b10, 2'b10, 1, 0, 0, 2'b00, 2'b01, 2'b00, 3'h0, 27'h0);
        row(23, 2'b10, 2'b10, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'h0, 27'h0);
        row(24, 2'b00, 2'b00, 1, 0, 1, 2'b10, 2'b10, 2'b00, 3'h0, 27'h80);
        for (int i = 25; i <= 31; i++) row(i, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b10, 2'b00, 3'h0, 27'h0);
        row(32, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'h0, 27'h0);

        // Reset values (asynchronous, no clock edge needed)
        #3;
        chk("rst cmd/cmd_en/addr", {cmd, cmd_en, addr}, '0);
        chk("rst wren/grant/wack", {ddr3_wren, cli_grant, cli_wack}, '0);
        chk("rst rvalid/orphan", {cli_rvalid, rd_orphan}, '0);

        @(negedge clk_ref);
        rst_n = 1'b1;

        // Before calibration no request is served
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            cli_req = 2'b01; cli_we = 2'b01; ddr3_wr_rdy = 1'b1;
            settle();
            chk($sformatf("idle no grant %0d", k), {cmd_en, cli_grant, cli_wack}, '0);
        end
        next_cycle();
        cli_req = 2'b00; cli_we = 2'b00; init_done = 1'b1;
        settle();
        next_cycle();
        settle();

        // Table-driven write/read sequence
        for (int i = 0; i < NVEC; i++) begin
            next_cycle();
            cli_req = tbl[i].req;
            cli_we = tbl[i].we;
            ddr3_wr_rdy = tbl[i].wr_rdy;
            ddr3_rd_valid = tbl[i].rd_v;
            ddr3_rd_data = {96'h0, 32'(1000 + i)};
            settle();
            chk($sformatf("vec%0d ctl", i),
                {cmd_en, cli_grant, cli_wack, cli_rvalid, ddr3_wren, ddr3_wr_end},
                {tbl[i].en, tbl[i].gnt, tbl[i].wack, tbl[i].rv, |tbl[i].wack, |tbl[i].wack});
            if (tbl[i].en)
                chk($sformatf("vec%0d cmd/addr", i), {cmd, addr}, {tbl[i].ecmd, tbl[i].eaddr});
            if (|tbl[i].wack)
                chk($sformatf("vec%0d wdata", i), ddr3_wr_data,
                    tbl[i].wack[1] ? wpat(1, widx[1]) : wpat(0, widx[0]));
            if (|tbl[i].rv)
                chk($sformatf("vec%0d rdata", i), cli_rdata, {96'h0, 32'(1000 + i)});
        end

        // Both clients read continuously: alternate grants until four tags are out
        for (int o = 0; o < 12; o++) begin
            next_cycle();
            cli_req = 2'b11; cli_we = 2'b00; ddr3_rd_valid = 1'b0;
            settle();
            eg = 2'b00;
            if ((o % 2) == 1 && o <= 7) eg = ((((o - 1) / 2) % 2) == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr o%0d grant", o), {cmd_en, cli_grant}, {|eg, eg});
            if (|eg) begin
                model_q.push_back(eg[1] ? 1 : 0);
                chk($sformatf("rr o%0d cmd/addr", o), {cmd, addr}, {3'h1, eg[1] ? 27'h80 : 27'h40});
            end
        end
        for (int k = 0; k < 32; k++) begin
            next_cycle();
            cli_req = 2'b00; ddr3_rd_valid = 1'b1;
            ddr3_rd_data = {96'h0, 32'(2000 + k)};
            settle();
            ev = (model_q[k / 8] == 1) ? 2'b10 : 2'b01;
            chk($sformatf("rr ret%0d rvalid", k), cli_rvalid, ev);
            chk($sformatf("rr ret%0d rdata", k), cli_rdata, {96'h0, 32'(2000 + k)});
        end
        next_cycle();
        ddr3_rd_valid = 1'b0;
        settle();
        chk("rr drained", {cli_rvalid, rd_orphan}, '0);

        // Client 1 wants a fifth read with no returns: held until a full burst pops
        for (int o = 0; o < 12; o++) begin
            next_cycle();
            cli_req = 2'b10; cli_we = 2'b00;
            settle();
            eg = ((o % 2) == 1 && o <= 7) ? 2'b10 : 2'b00;
            chk($sformatf("full o%0d grant", o), cli_grant, eg);
        end
        for (int b = 0; b < 10; b++) begin
            next_cycle();
            cli_req = (b < 9) ? 2'b10 : 2'b00;
            ddr3_rd_valid = (b < 8);
            settle();
            chk($sformatf("full b%0d rvalid", b), cli_rvalid, (b < 8) ? 2'b10 : 2'b00);
            chk($sformatf("full b%0d grant", b), cli_grant, (b == 9) ? 2'b10 : 2'b00);
        end
        for (int k = 0; k < 32; k++) begin
            next_cycle();
            ddr3_rd_valid = 1'b1;
            settle();
            chk($sformatf("full drain%0d", k), cli_rvalid, 2'b10);
        end

        // Read beat with nothing outstanding
        next_cycle();
        ddr3_rd_valid = 1'b1;
        settle();
        chk("orphan beat rvalid", {cli_rvalid, rd_orphan}, '0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            ddr3_rd_valid = 1'b0;
            settle();
            chk($sformatf("orphan sticky %0d", k), rd_orphan, 1'b1);
        end

        // Reset during beat 3 of a write
        next_cycle();
        cli_req = 2'b01; cli_we = 2'b01; ddr3_wr_rdy = 1'b1;
        settle();
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            cli_req = 2'b00;
            settle();
            chk($sformatf("pre-reset beat%0d", b), {cmd_en, cli_wack}, {(b == 0), 2'b01});
        end
        chk("orphan before reset", rd_orphan, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst cmd/cmd_en/addr", {cmd, cmd_en, addr}, '0);
        chk("async rst wren/wack/grant", {ddr3_wren, ddr3_wr_end, cli_wack, cli_grant}, '0);
        chk("async rst orphan", rd_orphan, 1'b0);
        wack_seen = 2'b00;
        widx[0] = 0;
        widx[1] = 0;
        @(negedge clk_ref);
        rst_n = 1'b1;
        next_cycle();
        settle();
        next_cycle();
        cli_req = 2'b01; cli_we = 2'b01;
        settle();
        for (int j = 0; j < 10; j++) begin
            next_cycle();
            cli_req = 2'b00;
            settle();
            chk($sformatf("restart j%0d", j), {cmd_en, cli_grant, cli_wack},
                {(j == 0), (j == 0) ? 2'b01 : 2'b00, (j < 8) ? 2'b01 : 2'b00});
            if (j < 8) chk($sformatf("restart j%0d wdata", j), ddr3_wr_data, wpat(0, j));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
